// File: rtl/divider_pkg.sv
// Shared types and constants for the divider scheduler: latency helper,
// the tag carried alongside each divide, and the divide-by-zero result.
package divider_pkg;

    localparam int M_DEF    = 26;
    localparam int N_DEF    = 14;
    localparam int NREQ_DEF = 4;
    localparam int TAG_IDW  = $clog2(NREQ_DEF);

    localparam logic [M_DEF-1:0] DZ_QUOTIENT = '1;

    function automatic int div_lat(input int m, input int n);
        return m - n + 1;
    endfunction

    typedef struct packed {
        logic               v;
        logic [TAG_IDW-1:0] id;
        logic               dz;
    } div_tag_t;

endpackage

// File: rtl/divider.sv
// Pipelined restoring divider: M quotient steps spread over STAGES register
// stages, one new operand pair per clock, no stall. Divisor must be nonzero.
module divider #(
    parameter int M      = 26,
    parameter int N      = 14,
    parameter int STAGES = 13
) (
    input  logic         clk,
    input  logic [M-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [M-1:0] quotient
);

    // Runs the steps owned by stage s; the shift register holds unconsumed
    // dividend bits on top and developed quotient bits underneath.
    function automatic logic [M-1:0] div_steps(input logic [N:0] rem_i, input logic [M-1:0] quo_i,
                                               input logic [N-1:0] d, input int s, input logic want_rem);
        logic [N:0]   r;
        logic [M-1:0] q;
        r = rem_i;
        q = quo_i;
        for (int j = 0; j < M; j++) begin
            if (j >= (s * M) / STAGES && j < ((s + 1) * M) / STAGES) begin
                r = {r[N-1:0], q[M-1]};
                q = {q[M-2:0], 1'b0};
                if (r >= {1'b0, d}) begin
                    r    = r - {1'b0, d};
                    q[0] = 1'b1;
                end
            end
        end
        return want_rem ? M'(r) : q;
    endfunction

    logic [M-1:0] quo_r [STAGES];
    logic [N:0]   rem_r [STAGES-1];
    logic [N-1:0] dvs_r [STAGES-1];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [N:0]   rem_in;
        logic [M-1:0] quo_in;
        logic [N-1:0] dvs_in;

        if (s == 0) begin : g_head
            assign rem_in = '0;
            assign quo_in = dividend;
            assign dvs_in = divisor;
        end else begin : g_body
            assign rem_in = rem_r[s-1];
            assign quo_in = quo_r[s-1];
            assign dvs_in = dvs_r[s-1];
        end

        always_ff @(posedge clk) begin
            quo_r[s] <= div_steps(rem_in, quo_in, dvs_in, s, 1'b0);
        end

        if (s < STAGES - 1) begin : g_carry
            always_ff @(posedge clk) begin
                rem_r[s] <= (N + 1)'(div_steps(rem_in, quo_in, dvs_in, s, 1'b1));
                dvs_r[s] <= dvs_in;
            end
        end
    end

    assign quotient = quo_r[STAGES-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from
// rr_ptr, pointer advanced past the winner on every grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] rr_ptr;
    logic           found;

    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_id;
        found   = 1'b0;
        gnt_id  = '0;
        gnt     = '0;
        cand    = 0;
        cand_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_id = IDW'(cand);
            if (!found && req[cand_id]) begin
                found  = 1'b1;
                gnt_id = cand_id;
            end
        end
        if (en && found) gnt[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/divider_sched.sv
// Shares one pipelined divider among NREQ requesters with round-robin issue;
// a tag pipe carries requester id and divide-by-zero status beside the data.
module divider_sched
    import divider_pkg::*;
#(
    parameter int M    = M_DEF,
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*M-1:0] req_dividend,
    input  logic [NREQ*N-1:0] req_divisor,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [M-1:0]      rsp_quotient,
    output logic              rsp_dz
);

    localparam int LAT = div_lat(M, N);
    localparam int STG = LAT - 1;

    // Handshake: requester i is accepted in a cycle where req_valid[i] and
    // req_ready[i] are both high; it keeps valid and operands stable until
    // then. Responses have no backpressure and pulse rsp_valid for one cycle.
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            arb_en;
    logic            accept;
    logic [N-1:0]    sel_divisor;
    logic            sel_dz;

    assign arb_en = !hold && !rst;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready   = gnt;
    assign accept      = |gnt;
    assign sel_divisor = req_divisor[gnt_id*N +: N];
    assign sel_dz      = (sel_divisor == '0);

    logic           iss_v;
    logic [IDW-1:0] iss_id;
    logic           iss_dz;
    logic [M-1:0]   iss_dividend;
    logic [N-1:0]   iss_divisor;

    // A zero divisor is replaced by 1 so the divider always sees a legal operand.
    always_ff @(posedge clk) begin
        if (rst) iss_v <= 1'b0;
        else     iss_v <= accept;
        if (accept) begin
            iss_id       <= gnt_id;
            iss_dz       <= sel_dz;
            iss_dividend <= req_dividend[gnt_id*M +: M];
            iss_divisor  <= sel_dz ? N'(1) : sel_divisor;
        end
    end

    logic [M-1:0] div_quotient;

    divider #(.M(M), .N(N), .STAGES(STG)) u_div (
        .clk      (clk),
        .dividend (iss_dividend),
        .divisor  (iss_divisor),
        .quotient (div_quotient)
    );

    div_tag_t tag_q [STG];
    div_tag_t last;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STG; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{v: iss_v, id: iss_id, dz: iss_dz};
            for (int i = 1; i < STG; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign last = tag_q[STG-1];

    always_comb begin
        rsp_valid    = last.v;
        rsp_id       = '0;
        rsp_dz       = 1'b0;
        rsp_quotient = '0;
        if (last.v) begin
            rsp_id       = last.id;
            rsp_dz       = last.dz;
            rsp_quotient = last.dz ? {M{1'b1}} : div_quotient;
        end
    end

endmodule

// File: tb/tb_divider_sched.sv
// Directed bench for divider_sched: the driver pushes hand-computed responses
// into exp_q at accept time, a monitor pops them as rsp_valid pulses arrive.
module tb_divider_sched;

    localparam int M    = 26;
    localparam int N    = 14;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 13;
    localparam int W    = 16 + IDW + 1 + M;

    logic              clk;
    logic              rst;
    logic              hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*M-1:0] req_dividend;
    logic [NREQ*N-1:0] req_divisor;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [M-1:0]      rsp_quotient;
    logic              rsp_dz;

    logic [M-1:0] dvd [NREQ];
    logic [N-1:0] dvs [NREQ];
    logic [M-1:0] eq  [NREQ];
    logic         edz [NREQ];

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    divider_sched #(.M(M), .N(N), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_quotient (rsp_quotient),
        .rsp_dz       (rsp_dz)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_dividend = '0;
        req_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*M +: M] = dvd[i];
            req_divisor[i*N +: N]  = dvs[i];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    // One cycle: check the grant, record the expected response, advance.
    task automatic tick(input logic [NREQ-1:0] exp_ready);
        logic [IDW-1:0] id;
        @(negedge clk);
        check("req_ready", req_ready, exp_ready);
        if (exp_ready != '0) begin
            id = '0;
            for (int i = 0; i < NREQ; i++) if (exp_ready[i]) id = IDW'(i);
            exp_q.push_back({16'(cyc + LAT), id, edz[id], eq[id]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [M-1:0] a, input logic [N-1:0] b,
                          input logic [M-1:0] q, input logic dz);
        dvd[id] = a;
        dvs[id] = b;
        eq[id]  = q;
        edz[id] = dz;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick('0);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 0);
        repeat (4) tick('0);
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_cycle", 64'(cyc), 64'(e[M+1+IDW +: 16]));
                        check("rsp_id", rsp_id, e[M+1 +: IDW]);
                        check("rsp_dz", rsp_dz, e[M]);
                        check("rsp_quotient", rsp_quotient, e[M-1:0]);
                    end
                end else begin
                    check("idle_quotient", rsp_quotient, 0);
                    if (exp_q.size() != 0 && 32'(exp_q[0][M+1+IDW +: 16]) <= cyc) begin
                        check("missing_rsp", 0, 1);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // driver
    initial begin
        rst = 1'b1;
        hold = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) set_op(i, '0, 14'd1, '0, 1'b0);
        @(posedge clk);
        #1;
        tick('0);
        tick('0);
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_dz", rsp_dz, 0);
        check("reset_rsp_quotient", rsp_quotient, 0);
        check("reset_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single op from requester 2, accepted in cycle 10
        while (cyc < 10) tick('0);
        set_op(2, 26'd1000000, 14'd7, 26'd142857, 1'b0);
        req_valid = 4'b0100;
        tick(4'b0100);
        req_valid = '0;
        drain();

        // streaming on requester 0
        req_valid = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            set_op(0, M'(3 * k + 1), 14'd3, M'(k), 1'b0);
            tick(4'b0001);
        end
        req_valid = '0;
        drain();

        // divide by zero between two ordinary ops on requester 1
        req_valid = 4'b0010;
        set_op(1, 26'd100, 14'd5, 26'd20, 1'b0);
        tick(4'b0010);
        set_op(1, 26'd12345, 14'd0, 26'h3FFFFFF, 1'b1);
        tick(4'b0010);
        set_op(1, 26'd99, 14'd9, 26'd11, 1'b0);
        tick(4'b0010);
        req_valid = '0;
        drain();

        // hold for 5 cycles with two ops in flight
        set_op(3, 26'd50, 14'd2, 26'd25, 1'b0);
        req_valid = 4'b1000;
        tick(4'b1000);
        set_op(0, 26'd81, 14'd9, 26'd9, 1'b0);
        req_valid = 4'b0001;
        tick(4'b0001);
        hold = 1'b1;
        req_valid = 4'b1111;
        repeat (5) tick('0);
        hold = 1'b0;
        req_valid = '0;
        drain();

        // reset with six ops in flight, then one new op right after
        for (int k = 0; k < 6; k++) begin
            set_op((k + 1) % 4, M'(1000 + k), 14'd1, M'(1000 + k), 1'b0);
            req_valid = 4'b0001 << ((k + 1) % 4);
            tick(4'b0001 << ((k + 1) % 4));
        end
        req_valid = '0;
        rst = 1'b1;
        exp_q.delete();
        tick('0);
        rst = 1'b0;
        set_op(2, 26'd77, 14'd7, 26'd11, 1'b0);
        req_valid = 4'b0100;
        tick(4'b0100);
        req_valid = '0;
        drain();

        // fairness from a fresh pointer
        rst = 1'b1;
        tick('0);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, M'(i * 7 + 14), 14'd7, M'(i + 2), 1'b0);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) tick(4'b0001 << (k % 4));
        req_valid = '0;
        drain();

        check("final_queue_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
